// File: rtl/apb_completer_regfile.sv
// -----------------------------------------------------------------------------
// apb_completer_regfile
//
// APB4 completer backed by a small word-addressed register file. Register 0 is
// a read-only ID constant; registers 1..NUM_REGS-1 are read/write with byte
// strobes. Every access phase lasts WAIT_STATES+1 cycles. Misaligned,
// out-of-range and register-0 writes complete with pslverr.
//
// Optional build macro: APB_PROT_CHECK_EN
//   When defined, registers with index >= NUM_REGS/2 are privileged. A setup
//   targeting them with pprot[0]=0 completes with pslverr, prdata=0 and no
//   write. When undefined, pprot is ignored.
//
// Ports:
//   pclk, presetn       clock, asynchronous active-low reset
//   paddr, pwdata       byte address, write data
//   pstrb, pprot        write byte strobes, protection type
//   pselx, penable      select, access-phase indicator
//   pwrite              1 = write, 0 = read
//   pready, prdata      registered completion, registered read data
//   pslverr             registered error response (only with pready)
//   regs_o              flattened register contents, register i at
//                       [i*DATA_WIDTH +: DATA_WIDTH] (slot 0 holds ID_VALUE)
//
// State | Meaning
// ------+----------------------------------------------------------------
// IDLE  | no transfer in progress, waiting for a setup phase
// ACCESS| transfer latched; counting wait states, then holding pready
// -----------------------------------------------------------------------------
module apb_completer_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [2:0]                     pprot,
    input  logic                           pselx,
    input  logic                           penable,
    input  logic                           pwrite,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int         NB     = DATA_WIDTH / 8;
    localparam int         OFFS   = $clog2(NB);
    localparam int         IDX_W  = ADDR_WIDTH - OFFS;
    localparam int         RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [RIDX_W-1:0]       lat_idx;
    logic                    lat_write;
    logic                    lat_err;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [NB-1:0]           lat_strb;
    logic [DATA_WIDTH-1:0]   lat_rdata;

    logic [DATA_WIDTH-1:0]   regs [1:NUM_REGS-1];

    logic [IDX_W-1:0]        setup_idx;
    logic                    setup_err;
    logic [DATA_WIDTH-1:0]   setup_rdata;
    logic                    priv_err;
    logic                    unused_prot;

`ifdef APB_PROT_CHECK_EN
    assign priv_err    = !pprot[0] && (setup_idx >= IDX_W'(NUM_REGS / 2));
    assign unused_prot = ^pprot[2:1];
`else
    assign priv_err    = 1'b0;
    assign unused_prot = ^pprot;
`endif

    // Decode of the address phase; everything the access needs is frozen at
    // setup, so later bus or register changes cannot alter the response.
    always_comb begin
        setup_idx = paddr[ADDR_WIDTH-1:OFFS];
        setup_err = (|(paddr & ADDR_WIDTH'(NB - 1)))
                  || (setup_idx >= IDX_W'(NUM_REGS))
                  || (pwrite && (setup_idx == '0))
                  || priv_err;
        setup_rdata = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (setup_idx == IDX_W'(i)) begin
                setup_rdata = regs[i];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            lat_rdata <= '0;
            pready    <= 1'b0;
            prdata    <= '0;
            pslverr   <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pselx && !penable) begin
                        lat_idx   <= setup_idx[RIDX_W-1:0];
                        lat_write <= pwrite;
                        lat_err   <= setup_err;
                        lat_wdata <= pwdata;
                        lat_strb  <= pstrb;
                        lat_rdata <= setup_rdata;
                        cnt       <= WS;
                        state     <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            prdata  <= (setup_err || pwrite) ? '0 : setup_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!pselx) begin
                        // Requester abandoned the transfer: drop it, no write.
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else if (!pready) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= lat_err;
                            prdata  <= (lat_err || lat_write) ? '0 : lat_rdata;
                        end
                    end else if (penable) begin
                        if (lat_write && !lat_err) begin
                            for (int i = 1; i < NUM_REGS; i++) begin
                                for (int k = 0; k < NB; k++) begin
                                    if ((lat_idx == RIDX_W'(i)) && lat_strb[k]) begin
                                        regs[i][k*8 +: 8] <= lat_wdata[k*8 +: 8];
                                    end
                                end
                            end
                        end
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        regs_o = '0;
        regs_o[DATA_WIDTH-1:0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Two completers share one bus: slot 0 built with one wait state, slot 1 with
// none. The transfer task drives whichever is selected and updates a simple
// array model; a negedge process checks both DUTs against that model.
module tb_apb_completer_regfile;

    localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic        pselx = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    bit          sel = 1'b0;

    logic        psel_a, psel_b;
    logic        rdy_a, rdy_b, err_a, err_b;
    logic [31:0] rd_a, rd_b;
    logic [255:0] regs_a, regs_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] mreg    [2][8];
    logic        exp_rdy [2];
    logic [31:0] exp_rd  [2];
    logic        exp_err [2];

    always #5 pclk = ~pclk;

    assign psel_a = pselx && !sel;
    assign psel_b = pselx && sel;

    apb_completer_regfile #(.WAIT_STATES(1)) u_ws1 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .pselx(psel_a), .penable(penable),
        .pwrite(pwrite), .pready(rdy_a), .prdata(rd_a), .pslverr(err_a),
        .regs_o(regs_a)
    );

    apb_completer_regfile #(.WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .pselx(psel_b), .penable(penable),
        .pwrite(pwrite), .pready(rdy_b), .prdata(rd_b), .pslverr(err_b),
        .regs_o(regs_b)
    );

    // ---------------- model ----------------
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mreg[d][i] = '0;
            exp_rdy[d] = 1'b0;
            exp_rd[d]  = '0;
            exp_err[d] = 1'b0;
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input bit wr, input logic [2:0] pr);
        bit e;
        e = (a[1:0] != 2'b00) || (a[31:2] >= 30'd8) || (wr && a[31:2] == 30'd0);
        if (PROT_EN && !pr[0] && a[31:2] >= 30'd4) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] model_read(input int d, input int idx);
        return (idx == 0) ? ID : mreg[d][idx];
    endfunction

    function automatic logic [255:0] model_regs(input int d);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = model_read(d, i);
        return v;
    endfunction

    task automatic model_write(input int d, input int idx, input logic [31:0] wd, input logic [3:0] st);
        for (int k = 0; k < 4; k++)
            if (st[k]) mreg[d][idx][k*8 +: 8] = wd[k*8 +: 8];
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_wide(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        chk("pready_ws1",  {31'b0, rdy_a}, {31'b0, exp_rdy[0]});
        chk("pslverr_ws1", {31'b0, err_a}, {31'b0, exp_err[0]});
        chk("prdata_ws1",  rd_a, exp_rd[0]);
        chk_wide("regs_o_ws1", regs_a, model_regs(0));
        chk("pready_ws0",  {31'b0, rdy_b}, {31'b0, exp_rdy[1]});
        chk("pslverr_ws0", {31'b0, err_b}, {31'b0, exp_err[1]});
        chk("prdata_ws0",  rd_b, exp_rd[1]);
        chk_wide("regs_o_ws0", regs_b, model_regs(1));
    end

    // ---------------- stimulus ----------------
    // Entered and left at posedge+1; the next call may start immediately,
    // giving a back-to-back setup right after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr, input bit abort,
                        output logic [31:0] rd, output logic er);
        int ws;
        bit e;
        logic [31:0] r;
        ws = (d == 0) ? 1 : 0;
        e  = model_err(a, wr, pr);
        r  = (e || wr) ? 32'h0 : model_read(d, int'(a[4:2]));
        sel = (d == 1);
        pselx = 1'b1; penable = 1'b0; paddr = a; pwrite = wr;
        pwdata = wd; pstrb = st; pprot = pr;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 1; k <= ws + 1; k++) begin
            if (k > 1) begin @(posedge pclk); #1; end
            if (abort) pselx = 1'b0;
            if (k == ws + 1) begin
                exp_rdy[d] = 1'b1; exp_rd[d] = r; exp_err[d] = e;
            end
            if (abort) break;
        end
        rd = (d == 0) ? rd_a : rd_b;
        er = (d == 0) ? err_a : err_b;
        @(posedge pclk); #1;
        if (!abort && wr && !e) model_write(d, int'(a[4:2]), wd, st);
        exp_rdy[d] = 1'b0; exp_rd[d] = '0; exp_err[d] = 1'b0;
        pselx = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        model_reset();
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        idle(1);

        // ID register, one wait state
        xfer(0, 0, 32'h0, '0, 4'h0, 3'b001, 0, rd, er);
        chk("id_read_data", rd, 32'hA9B0_0001);
        chk("id_read_err", {31'b0, er}, 32'h0);

        // full write and readback
        xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'b1111, 3'b001, 0, rd, er);
        chk("wr4_err", {31'b0, er}, 32'h0);
        chk("wr4_regs_o", regs_a[63:32], 32'hDEAD_BEEF);
        xfer(0, 0, 32'h4, '0, 4'h0, 3'b001, 0, rd, er);
        chk("rd4_data", rd, 32'hDEAD_BEEF);

        // partial strobe merge
        xfer(0, 1, 32'h4, 32'h1122_3344, 4'b0101, 3'b001, 0, rd, er);
        xfer(0, 0, 32'h4, '0, 4'b0000, 3'b001, 0, rd, er);
        chk("rd4_strobe_merge", rd, 32'hDE22_BE44);

        // error responses: out of range, misaligned, register 0
        xfer(0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, rd, er);
        chk("err_range", {31'b0, er}, 32'h1);
        xfer(0, 1, 32'h2, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, rd, er);
        chk("err_misaligned", {31'b0, er}, 32'h1);
        xfer(0, 1, 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, rd, er);
        chk("err_reg0", {31'b0, er}, 32'h1);
        chk("err_no_change", regs_a[63:32], 32'hDE22_BE44);
        xfer(0, 0, 32'h24, '0, 4'h0, 3'b001, 0, rd, er);
        chk("err_read_range", {31'b0, er}, 32'h1);
        chk("err_read_data", rd, 32'h0);

        // back-to-back on the zero-wait completer
        xfer(1, 1, 32'h8, 32'hCAFE_F00D, 4'hF, 3'b001, 0, rd, er);
        xfer(1, 0, 32'h8, '0, 4'h0, 3'b001, 0, rd, er);
        chk("b2b_read", rd, 32'hCAFE_F00D);
        idle(1);

        // aborted write leaves register untouched
        xfer(0, 1, 32'h8, 32'h1234_5678, 4'hF, 3'b001, 1, rd, er);
        xfer(0, 0, 32'h8, '0, 4'h0, 3'b001, 0, rd, er);
        chk("abort_no_write", rd, 32'h0);

`ifdef APB_PROT_CHECK_EN
        xfer(0, 1, 32'h18, 32'h0BAD_0BAD, 4'hF, 3'b000, 0, rd, er);
        chk("prot_denied_err", {31'b0, er}, 32'h1);
        chk("prot_denied_nowr", regs_a[223:192], 32'h0);
        xfer(0, 1, 32'h18, 32'h600D_600D, 4'hF, 3'b001, 0, rd, er);
        chk("prot_ok_err", {31'b0, er}, 32'h0);
        xfer(0, 0, 32'h18, '0, 4'h0, 3'b001, 0, rd, er);
        chk("prot_ok_read", rd, 32'h600D_600D);
`endif

        // randomized traffic across both completers
        for (int n = 0; n < 400; n++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 9)) << 2;
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0), rd, er);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        // reset during the wait state of a write to 0xC
        sel = 1'b0;
        pselx = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1;
        pwdata = 32'h5A5A_5A5A; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1 presetn = 1'b0;
        model_reset();
        #1 chk("reset_pready", {31'b0, rdy_a}, 32'h0);
        pselx = 1'b0; penable = 1'b0;
        idle(2);
        presetn = 1'b1;
        idle(1);
        xfer(0, 0, 32'hC, '0, 4'h0, 3'b001, 0, rd, er);
        chk("reset_discards_write", rd, 32'h0);

        // reset while pready is high
        xfer(0, 1, 32'h10, 32'h7777_8888, 4'hF, 3'b001, 0, rd, er);
        sel = 1'b0;
        pselx = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        exp_rdy[0] = 1'b1; exp_rd[0] = 32'h7777_8888;
        @(negedge pclk); #1;
        presetn = 1'b0;
        model_reset();
        #1 chk("reset_drops_ready", {31'b0, rdy_a}, 32'h0);
        chk("reset_drops_prdata", rd_a, 32'h0);
        pselx = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        idle(1);
        presetn = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
- APB4 completer (slave) that terminates transfers from the APB requester and backs them with a small memory-mapped register file.
- Sits on the slave side of the APB interface. Exposes register contents to downstream logic in parallel.
- Supports programmable wait states, byte strobes and error response.

Parameters:
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width. Multiple of 8.
- NUM_REGS, 8, number of word registers. Register 0 is read-only.
- WAIT_STATES, 1, access-phase wait cycles before pready (0..15).
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0.

Ports:
- pclk  in  1  APB clock.
- presetn  in  1  Asynchronous active-low reset.
- paddr  in  ADDR_WIDTH  Byte address.
- pwdata  in  DATA_WIDTH  Write data.
- pstrb  in  DATA_WIDTH/8  Write byte strobes.
- pprot  in  3  Protection type.
- pselx  in  1  Completer select.
- penable  in  1  Access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- pready  out  1  Transfer complete.
- prdata  out  DATA_WIDTH  Read data.
- pslverr  out  1  Error response.
- regs_o  out  NUM_REGS*DATA_WIDTH  Flattened register contents. Register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Clocking and reset: one clock, pclk. Reset presetn is asynchronous and active-low.
- Reset values: pready=0, prdata=0, pslverr=0, all registers 0 (register 0 reads ID_VALUE), FSM=IDLE, wait counter=0.
- Addressing: index = paddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
- Error condition, evaluated at setup:
  - paddr low byte-offset bits nonzero, OR
  - index >= NUM_REGS, OR
  - write to index 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge sampling pselx=1 and penable=0, latch index, pwrite, pwdata, pstrb and error; load counter with WAIT_STATES; go to ACCESS.
  - If WAIT_STATES=0, also set pready<=1 on that edge, with prdata and pslverr valid.
- ACCESS, pready=0:
  - Decrement counter.
  - When counter==1, set pready<=1 and drive prdata (read data, or 0 on error or write) and pslverr (error flag) in the same edge.
- ACCESS, pready=1 (completion edge, pselx=1 and penable=1 sampled):
  - If write and no error, commit the latched data: byte k of the register updates only where pstrb[k]=1.
  - Clear pready, pslverr and prdata; return to IDLE.
- pready, prdata and pslverr are registered. pslverr is high only while pready is high.
- Read data is the register value captured at setup. A read never modifies state; pstrb is ignored on reads.
- Error writes never modify any register.
- Back-to-back transfers: a new setup in the cycle immediately after completion is accepted. Throughput is one transfer per WAIT_STATES+2 cycles.
- Aborted access: pselx=0 sampled in ACCESS returns to IDLE, clears outputs, and commits no write.
- Reset asserted mid-transfer: the FSM and outputs return to reset values immediately. The pending write is discarded.
- regs_o updates the cycle after the completion edge.

Optional Feature:
- Macro: APB_PROT_CHECK_EN.
- Defined: registers with index >= NUM_REGS/2 are privileged. A setup with pprot[0]=0 targeting them is flagged as an error:
  - pslverr=1 at completion,
  - prdata=0,
  - no write.
- Undefined: pprot is ignored and only the base error conditions apply.

Test Plan:
- Reset, then read index 0 (paddr=0x0) with WAIT_STATES=1 -> pready high in the 2nd access cycle, prdata=0xA9B00001, pslverr=0.
- Write 0xDEADBEEF to paddr=0x4 with pstrb=4'b1111, then read it back -> prdata=0xDEADBEEF, regs_o[63:32]=0xDEADBEEF.
- Write 0x11223344 to paddr=0x4 with pstrb=4'b0101 over 0xDEADBEEF -> readback 0xDE22BE44.
- Write to paddr=0x20 (index 8), to paddr=0x2 (misaligned) and to paddr=0x0 -> each gives pslverr=1 with pready; no register changes.
- Back-to-back write then read to paddr=0x8 with no idle cycle, WAIT_STATES=0 -> each access phase completes in 1 cycle; the read returns the written value.
- Assert presetn low during the ACCESS wait of a write to 0xC -> pready=0 immediately; after reset, reading 0xC returns 0. With APB_PROT_CHECK_EN defined: write to 0x18 with pprot=3'b000 -> pslverr=1, no write; the same write with pprot=3'b001 succeeds.
